alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Parametrised execute-stage successor to the combinational ALU control decoder.
- Decodes alu_op/fn3/fn7_5/imm11_5 into the team's 4-bit ALU control code and executes the operation on XLEN-bit operands.
- Optional iterative shifter and optional iterative multiplier.
- Sits between ID/EX operand latch and writeback/branch logic, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, operand/result width; power of two, 8..64.
- SHIFT_ITER, 0, 0 = single-cycle barrel shift; 1 = shift one bit position per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_en  in  1  execute enable; 0 forces control code 0000 (add)
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts operation
- alu_op  in  3  class: 000 R, 001 I, 010 load, 011 store, 100 branch, 101 jal/jalr
- fn3  in  3  funct3
- fn7_5  in  1  funct7 bit 5
- fn7_0  in  1  funct7 bit 0 (M-extension select; used only with ALU_MUL_EN)
- imm11_5  in  7  immediate[11:5]
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B / immediate
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  ALU result; for branches bit0 = taken, other bits 0
- ctrl_out  out  4  decoded control code of the held result
- illegal  out  1  decode fell to default (I-type fn3=101 with imm11_5 not 00/20, R/load/store with unlisted fn3)

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; result=0; ctrl_out=0; illegal=0.
- Control codes: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, A beq, B bne, C blt, D bge, E bltu, F bgeu.
- Load, store, jal/jalr, and illegal decodes use code 0 (add); illegal raises the illegal flag.
- Shift amount = op_b[$clog2(XLEN)-1:0]. slt/blt/bge are signed; sltu/bltu/bgeu are unsigned. add/sub wrap modulo 2^XLEN.
- FSM states: IDLE, SHIFT, MUL, DONE.
- IDLE: in_ready=1. Accept on in_valid.
  - Single-cycle op: go to DONE; out_valid is asserted the next cycle (latency 1).
  - Shift with SHIFT_ITER=1 and shamt>0: go to SHIFT; one bit per cycle; go to DONE after shamt cycles (latency 1+shamt).
  - shamt=0: behaves as single-cycle.
  - sra fills with the original sign bit.
- DONE: out_valid=1; result, ctrl_out and illegal are held stable until out_ready.
  - On out_ready, in_ready is also 1 that cycle: a simultaneous in_valid is accepted (back-to-back, throughput 1/cycle for single-cycle ops).
  - Otherwise return to IDLE.
- in_ready=0 in SHIFT and MUL. Inputs are ignored in those states; operands are captured at acceptance.
- rst asserted in any state, including mid-SHIFT/MUL: the next cycle is in reset state and the in-flight op is dropped without out_valid.
- ex_en is sampled at acceptance only.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - alu_op=000, fn7_0=1, fn3=000 performs MUL: low XLEN bits of op_a*op_b via shift-add, one bit per cycle, in state MUL.
  - Latency 1+XLEN. ctrl_out=0000. illegal=0.
  - Other fn3 values with fn7_0=1 are illegal and produce add.
- Not defined: MUL state absent; fn7_0 is ignored; decode is identical to the base table.

Decomposition:
- Package alu_pkg:
  - enum alu_ctrl_e (16 codes)
  - alu_op class constants
  - enum exec_state_e {IDLE, SHIFT, MUL, DONE}
  - SRAI_IMM = 7'h20
- Sub-module alu_decode: purely combinational; (alu_op, fn3, fn7_5, fn7_0, imm11_5, ex_en) -> (ctrl, illegal, is_shift, is_mul). Reused by other pipelines.

Test Plan:
- Reset: hold rst 2 cycles mid-SHIFT with shamt=20 -> out_valid=0, in_ready=1, result=0 after reset; no stale result appears.
- R-type sub (alu_op=000, fn3=000, fn7_5=1), a=5, b=7, out_ready=1 -> one cycle later out_valid=1, result=32'hFFFF_FFFE, ctrl_out=0001.
- Branch blt a=32'hFFFF_FFFF, b=1 -> result=1, ctrl_out=1100; bltu with the same operands -> result=0, ctrl_out=1110.
- SHIFT_ITER=1 srai (alu_op=001, fn3=101, imm11_5=7'h20), a=32'h8000_0000, b=4 -> out_valid exactly 5 cycles after accept, result=32'hF800_0000. Same with imm11_5=7'h10 -> illegal=1, result=32'h8000_0004.
- Backpressure: out_ready=0 for 3 cycles with a new in_valid pending -> result held, in_ready=0; on out_ready=1 the new op is accepted that same cycle and its result is valid next cycle.
- ALU_MUL_EN: mul a=12345, b=678 -> result=8369910 after XLEN+1 cycles. ex_en=0 with xor operands 3, 5 -> result=8 (add).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: control codes, operation classes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_ADD  = 4'h0,
    CTRL_SUB  = 4'h1,
    CTRL_XOR  = 4'h2,
    CTRL_OR   = 4'h3,
    CTRL_AND  = 4'h4,
    CTRL_SLL  = 4'h5,
    CTRL_SRL  = 4'h6,
    CTRL_SRA  = 4'h7,
    CTRL_SLT  = 4'h8,
    CTRL_SLTU = 4'h9,
    CTRL_BEQ  = 4'hA,
    CTRL_BNE  = 4'hB,
    CTRL_BLT  = 4'hC,
    CTRL_BGE  = 4'hD,
    CTRL_BLTU = 4'hE,
    CTRL_BGEU = 4'hF
  } alu_ctrl_e;

  localparam logic [2:0] OP_R      = 3'b000;
  localparam logic [2:0] OP_I      = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_JAL    = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } exec_state_e;

  localparam logic [6:0] SRAI_IMM = 7'h20;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decoder; ALU_MUL_EN adds the fn7_0 multiply select on R-type.
module alu_decode
  import alu_pkg::*;
(
  input  logic       ex_en,
  input  logic [2:0] alu_op,
  input  logic [2:0] fn3,
  input  logic       fn7_5,
  input  logic       fn7_0,
  input  logic [6:0] imm11_5,
  output alu_ctrl_e  ctrl,
  output logic       illegal,
  output logic       is_shift,
  output logic       is_mul
);

`ifndef ALU_MUL_EN
  logic unused_fn7_0;
  assign unused_fn7_0 = fn7_0;
`endif

  always_comb begin
    ctrl     = CTRL_ADD;
    illegal  = 1'b0;
    is_shift = 1'b0;
    is_mul   = 1'b0;
    if (ex_en) begin
      case (alu_op)
        OP_R: begin
          case (fn3)
            3'b000:  ctrl = fn7_5 ? CTRL_SUB : CTRL_ADD;
            3'b001:  ctrl = CTRL_SLL;
            3'b010:  ctrl = CTRL_SLT;
            3'b011:  ctrl = CTRL_SLTU;
            3'b100:  ctrl = CTRL_XOR;
            3'b101:  ctrl = fn7_5 ? CTRL_SRA : CTRL_SRL;
            3'b110:  ctrl = CTRL_OR;
            default: ctrl = CTRL_AND;
          endcase
`ifdef ALU_MUL_EN
          if (fn7_0) begin
            ctrl    = CTRL_ADD;
            is_mul  = (fn3 == 3'b000);
            illegal = (fn3 != 3'b000);
          end
`endif
        end
        OP_I: begin
          case (fn3)
            3'b000: ctrl = CTRL_ADD;
            3'b001: ctrl = CTRL_SLL;
            3'b010: ctrl = CTRL_SLT;
            3'b011: ctrl = CTRL_SLTU;
            3'b100: ctrl = CTRL_XOR;
            3'b101: begin
              if (imm11_5 == 7'h00)          ctrl = CTRL_SRL;
              else if (imm11_5 == SRAI_IMM)  ctrl = CTRL_SRA;
              else                           illegal = 1'b1;
            end
            3'b110:  ctrl = CTRL_OR;
            default: ctrl = CTRL_AND;
          endcase
        end
        OP_LOAD:  illegal = !(fn3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        OP_STORE: illegal = !(fn3 inside {3'b000, 3'b001, 3'b010});
        OP_BRANCH: begin
          case (fn3)
            3'b000:  ctrl = CTRL_BEQ;
            3'b001:  ctrl = CTRL_BNE;
            3'b100:  ctrl = CTRL_BLT;
            3'b101:  ctrl = CTRL_BGE;
            3'b110:  ctrl = CTRL_BLTU;
            3'b111:  ctrl = CTRL_BGEU;
            default: ctrl = CTRL_ADD;
          endcase
        end
        OP_JAL:  ctrl = CTRL_ADD;
        default: illegal = 1'b1;
      endcase
    end
    is_shift = (ctrl == CTRL_SLL) || (ctrl == CTRL_SRL) || (ctrl == CTRL_SRA);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes, optional iterative shifter (SHIFT_ITER)
// and optional shift-add multiplier enabled by the ALU_MUL_EN macro.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_ITER = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [2:0]      fn3,
  input  logic            fn7_5,
  input  logic            fn7_0,
  input  logic [6:0]      imm11_5,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      ctrl_out,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  exec_state_e     state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  alu_ctrl_e       ctrl_q, ctrl_d;
  logic            ill_q, ill_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  alu_ctrl_e       dec_ctrl;
  logic            dec_ill, dec_shift, dec_mul;
  logic [SHW-1:0]  shamt;
  logic            accept;

  alu_decode u_decode (
    .ex_en    (ex_en),
    .alu_op   (alu_op),
    .fn3      (fn3),
    .fn7_5    (fn7_5),
    .fn7_0    (fn7_0),
    .imm11_5  (imm11_5),
    .ctrl     (dec_ctrl),
    .illegal  (dec_ill),
    .is_shift (dec_shift),
    .is_mul   (dec_mul)
  );

  function automatic logic [XLEN-1:0] alu_calc(alu_ctrl_e c, logic [XLEN-1:0] a,
                                               logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    r  = '0;
    case (c)
      CTRL_ADD:  r = a + b;
      CTRL_SUB:  r = a - b;
      CTRL_XOR:  r = a ^ b;
      CTRL_OR:   r = a | b;
      CTRL_AND:  r = a & b;
      CTRL_SLL:  r = a << sh;
      CTRL_SRL:  r = a >> sh;
      CTRL_SRA:  r = sa >>> sh;
      CTRL_SLT:  r[0] = (sa < sb);
      CTRL_SLTU: r[0] = (a < b);
      CTRL_BEQ:  r[0] = (a == b);
      CTRL_BNE:  r[0] = (a != b);
      CTRL_BLT:  r[0] = (sa < sb);
      CTRL_BGE:  r[0] = (sa >= sb);
      CTRL_BLTU: r[0] = (a < b);
      default:   r[0] = (a >= b);
    endcase
    return r;
  endfunction

  // One bit position per cycle; sra keeps replicating the original sign bit.
  function automatic logic [XLEN-1:0] shift_one(alu_ctrl_e c, logic [XLEN-1:0] v);
    case (c)
      CTRL_SLL: return {v[XLEN-2:0], 1'b0};
      CTRL_SRA: return {v[XLEN-1], v[XLEN-1:1]};
      default:  return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mpl_q, mpl_d;
  logic [XLEN-1:0] mcd_q, mcd_d;

  always_ff @(posedge clk) begin
    mpl_q <= mpl_d;
    mcd_q <= mcd_d;
  end
`else
  logic unused_mul;
  assign unused_mul = dec_mul;
`endif

  assign shamt     = op_b[SHW-1:0];
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign ctrl_out  = ctrl_q;
  assign illegal   = ill_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
`ifdef ALU_MUL_EN
    mpl_d   = mpl_q;
    mcd_d   = mcd_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (accept) begin
          ctrl_d = dec_ctrl;
          ill_d  = dec_ill;
`ifdef ALU_MUL_EN
          mpl_d  = op_a;
          mcd_d  = op_b;
          if (dec_mul) begin
            res_d   = '0;
            cnt_d   = CW'(XLEN);
            state_d = MUL;
          end else
`endif
          if (dec_shift && (SHIFT_ITER != 0) && (shamt != '0)) begin
            res_d   = op_a;
            cnt_d   = CW'(shamt);
            state_d = SHIFT;
          end else begin
            res_d   = alu_calc(dec_ctrl, op_a, op_b);
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        res_d = shift_one(ctrl_q, res_q);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      default: begin
`ifdef ALU_MUL_EN
        if (mpl_q[0]) res_d = res_q + mcd_q;
        mpl_d = mpl_q >> 1;
        mcd_d = mcd_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      ctrl_q  <= CTRL_ADD;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
